sdram_cmd_sched: RTL and testbench
==================================

// Module: sdram_cmd_sched
// PURPOSE
// Owns the SDRAM command bus outside data transfers: runs the power-up init sequence and periodic auto-refresh.
// Arbitrates the bus between its own maintenance commands and the AHB access engine through a req/gnt/done handshake.
// Sits between the access engine and the MEM_* pins; bus_sel drives the top-level command/address mux.
// PARAMETERS
// PWRUP_CYC     5000    NOP cycles after reset before first command (100 us at 20 ns)
// TRP_CYC       1       precharge-to-next-command wait, cycles (>=1)
// TRFC_CYC      3       auto-refresh-to-next-command wait, cycles (>=1)
// TMRD_CYC      2       load-mode-to-next-command wait, cycles (>=1)
// INIT_REFS     2       auto-refresh commands issued during init (>=1)
// REF_INTERVAL  750     cycles between refresh requests (15 us)
// MODE_REG      12'h010 value placed on sch_addr for LOAD MODE (BL=1, sequential, CL=1)
// PORTS
// HCLK         in   1   clock
// HRESETn      in   1   async active-low reset
// acc_req      in   1   access engine wants the bus (level)
// acc_done     in   1   1-cycle pulse: transfer finished, all banks precharged
// acc_gnt      out  1   access engine owns the bus
// ref_urgent   out  1   refresh pending while granted; engine should finish soon
// init_done    out  1   init sequence complete (sticky until reset)
// ref_overrun  out  1   sticky: refresh interval expired while one already pending
// bus_sel      out  1   0 = scheduler drives MEM_*, 1 = access engine drives
// sch_cke      out  1   CKE
// sch_cmd      out  4   {CSn,RASn,CASn,WEn}
// sch_addr     out  12  address / mode bits
// sch_ba       out  2   bank address
// BEHAVIOUR
// Encodings: NOP=4'b0111, PRECHARGE=4'b0010 (sch_addr[10]=1, all banks), AUTO_REFRESH=4'b0001, LOAD_MODE=4'b0000; DESELECT=4'b1111.
// All outputs are registered. Reset values: sch_cke=0, sch_cmd=DESELECT, sch_addr=0, sch_ba=0, bus_sel=0, acc_gnt=0, ref_urgent=0, init_done=0, ref_overrun=0.
// Every command is held exactly 1 cycle, then NOP for the wait count. sch_addr=0 except for PRECHARGE (12'h400) and LOAD_MODE (MODE_REG). sch_ba=0 always.
// FSM: PWRUP -> I_PRE -> I_TRP -> I_REF -> I_TRFC -> (repeat I_REF until INIT_REFS done) -> I_LMR -> I_TMRD -> IDLE.
// PWRUP: sch_cke=1 and cmd=NOP from the first cycle after reset release; lasts PWRUP_CYC cycles.
// Wait states load dcnt=N-1 and leave the state when dcnt==0. init_done rises on entry to IDLE.
// Refresh timer: free-runs only while init_done=1. On reaching REF_INTERVAL-1 it sets ref_pending and reloads 0.
// Expiry while ref_pending=1 sets ref_overrun. Expiry and clear in the same cycle: pending stays 1, no overrun.
// IDLE: ref_pending has priority -> R_PRE -> R_TRP -> R_REF -> R_TRFC -> IDLE. ref_pending clears when the AUTO_REFRESH command issues.
// IDLE with acc_req=1 and ref_pending=0 -> GRANT: acc_gnt=1 and bus_sel=1 from the next cycle. Grant latency is 1 cycle.
// GRANT: hold until acc_done=1. acc_gnt and bus_sel drop the following cycle, then the FSM returns to IDLE.
// At least one IDLE cycle separates consecutive grants. acc_req is ignored before init_done=1.
// ref_urgent = ref_pending & acc_gnt (registered). Refresh never preempts a grant. acc_done outside GRANT is ignored.
// While bus_sel=1, sch_cmd=NOP and sch_cke=1.
// Async reset mid-operation: all outputs return to reset values immediately and the full init sequence restarts.
// TESTING
// T1 PWRUP_CYC=4, defaults otherwise: after reset release, sch_cmd = 4 NOPs, PRECHARGE addr 12'h400, NOP, REF, NOP x2, REF, NOP x2, LMR addr 12'h010, NOP, then init_done=1.
// T2 acc_req=1 in IDLE -> acc_gnt=1, bus_sel=1 next cycle; pulse acc_done -> gnt=0 next cycle; req held -> re-grant after 1 IDLE cycle.
// T3 REF_INTERVAL=20, no requests -> PRECHARGE, REF pair every 20 cycles; ref_pending clears on REF issue.
// T4 Interval expires during a grant -> ref_urgent=1; refresh starts right after acc_done, even with acc_req still high.
// T5 Grant held past 2 intervals -> ref_overrun=1 and stays 1; only one refresh is issued after release.
// T6 HRESETn low during R_TRFC -> sch_cke=0, sch_cmd=4'b1111, init_done=0 at once; T1 sequence repeats after release.

Source files
------------

// File: rtl/sdram_cmd_sched.sv
// sdram_cmd_sched: SDRAM maintenance command scheduler and bus arbiter.
// Runs the power-up init sequence and periodic auto-refresh, and lends the
// command bus to the access engine through an acc_req/acc_gnt/acc_done handshake.
// Ports:
//   HCLK, HRESETn          clock, async active-low reset
//   acc_req, acc_done      access engine bus request (level) / transfer done (pulse)
//   acc_gnt, ref_urgent    grant to access engine / refresh pending during grant
//   init_done, ref_overrun init complete (sticky) / refresh interval missed (sticky)
//   bus_sel                0 = scheduler owns MEM_*, 1 = access engine owns MEM_*
//   sch_cke, sch_cmd, sch_addr, sch_ba   scheduler-side SDRAM command pins
module sdram_cmd_sched #(
  parameter int unsigned PWRUP_CYC    = 5000,
  parameter int unsigned TRP_CYC      = 1,
  parameter int unsigned TRFC_CYC     = 3,
  parameter int unsigned TMRD_CYC     = 2,
  parameter int unsigned INIT_REFS    = 2,
  parameter int unsigned REF_INTERVAL = 750,
  parameter logic [11:0] MODE_REG     = 12'h010
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        acc_req,
  input  logic        acc_done,
  output logic        acc_gnt,
  output logic        ref_urgent,
  output logic        init_done,
  output logic        ref_overrun,
  output logic        bus_sel,
  output logic        sch_cke,
  output logic [3:0]  sch_cmd,
  output logic [11:0] sch_addr,
  output logic [1:0]  sch_ba
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam logic [3:0] CMD_DES = 4'b1111;

  // Wait counts are command-to-command spacings; the command cycle itself
  // counts, but at least one NOP always follows a command.
  localparam int unsigned TRP_LD  = (TRP_CYC  > 1) ? TRP_CYC  - 2 : 0;
  localparam int unsigned TRFC_LD = (TRFC_CYC > 1) ? TRFC_CYC - 2 : 0;
  localparam int unsigned TMRD_LD = (TMRD_CYC > 1) ? TMRD_CYC - 2 : 0;

  localparam int unsigned DMAX = (PWRUP_CYC > TRFC_CYC) ?
                                 ((PWRUP_CYC > TMRD_CYC) ? PWRUP_CYC : TMRD_CYC) :
                                 ((TRFC_CYC > TMRD_CYC) ? TRFC_CYC : TMRD_CYC);
  localparam int unsigned DMAX2 = (DMAX > TRP_CYC) ? DMAX : TRP_CYC;
  localparam int unsigned CW    = $clog2(DMAX2 + 1);
  localparam int unsigned RW    = $clog2(INIT_REFS + 1);
  localparam int unsigned TW    = $clog2(REF_INTERVAL + 1);

  typedef enum logic [3:0] {
    PWRUP, I_PRE, I_TRP, I_REF, I_TRFC, I_LMR, I_TMRD,
    IDLE, R_PRE, R_TRP, R_REF, R_TRFC, GRANT
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   dcnt, dcnt_d;
  logic [RW-1:0]   rcnt, rcnt_d;
  logic [TW-1:0]   rtmr, rtmr_d;
  logic            ref_pending, pend_d, ovr_d;
  logic            ref_expire, ref_clr;
  logic [3:0]      cmd_d;
  logic [11:0]     addr_d;
  logic            gnt_d, init_d, urgent_d;

  // State register; power-up wait counts from reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= PWRUP;
      dcnt  <= CW'(PWRUP_CYC);
      rcnt  <= '0;
    end else begin
      state <= state_d;
      dcnt  <= dcnt_d;
      rcnt  <= rcnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    dcnt_d  = (dcnt != '0) ? dcnt - CW'(1) : dcnt;
    rcnt_d  = rcnt;
    case (state)
      PWRUP:  if (dcnt == '0) state_d = I_PRE;
      I_PRE:  begin state_d = I_TRP; dcnt_d = CW'(TRP_LD); end
      I_TRP:  if (dcnt == '0) begin state_d = I_REF; rcnt_d = RW'(INIT_REFS - 1); end
      I_REF:  begin state_d = I_TRFC; dcnt_d = CW'(TRFC_LD); end
      I_TRFC: if (dcnt == '0) begin
                if (rcnt == '0) state_d = I_LMR;
                else begin state_d = I_REF; rcnt_d = rcnt - RW'(1); end
              end
      I_LMR:  begin state_d = I_TMRD; dcnt_d = CW'(TMRD_LD); end
      I_TMRD: if (dcnt == '0) state_d = IDLE;
      IDLE:   if (ref_pending) state_d = R_PRE;
              else if (acc_req) state_d = GRANT;
      R_PRE:  begin state_d = R_TRP; dcnt_d = CW'(TRP_LD); end
      R_TRP:  if (dcnt == '0) state_d = R_REF;
      R_REF:  begin state_d = R_TRFC; dcnt_d = CW'(TRFC_LD); end
      R_TRFC: if (dcnt == '0) state_d = IDLE;
      GRANT:  if (acc_done) state_d = IDLE;
      default: state_d = PWRUP;
    endcase
  end

  // Refresh timer and pending/overrun bookkeeping; an expiry coinciding with
  // the REF issue keeps the new request pending without flagging overrun.
  always_comb begin
    ref_expire = init_done && (rtmr == TW'(REF_INTERVAL - 1));
    ref_clr    = (state_d == R_REF);
    pend_d     = ref_expire | (ref_pending & ~ref_clr);
    ovr_d      = ref_overrun | (ref_expire & ref_pending & ~ref_clr);
    if (!init_done || ref_expire) rtmr_d = '0;
    else                          rtmr_d = rtmr + TW'(1);
  end

  // Output decode from the upcoming state, so pins line up with the state.
  always_comb begin
    cmd_d    = CMD_NOP;
    addr_d   = '0;
    gnt_d    = 1'b0;
    case (state_d)
      I_PRE, R_PRE: begin cmd_d = CMD_PRE; addr_d = 12'h400; end
      I_REF, R_REF: cmd_d = CMD_REF;
      I_LMR:        begin cmd_d = CMD_LMR; addr_d = MODE_REG; end
      GRANT:        gnt_d = 1'b1;
      default:      ;
    endcase
    init_d   = init_done | (state_d == IDLE);
    urgent_d = pend_d & gnt_d;
  end

  // Registered outputs and refresh state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rtmr        <= '0;
      ref_pending <= 1'b0;
      ref_overrun <= 1'b0;
      init_done   <= 1'b0;
      acc_gnt     <= 1'b0;
      bus_sel     <= 1'b0;
      ref_urgent  <= 1'b0;
      sch_cke     <= 1'b0;
      sch_cmd     <= CMD_DES;
      sch_addr    <= '0;
      sch_ba      <= '0;
    end else begin
      rtmr        <= rtmr_d;
      ref_pending <= pend_d;
      ref_overrun <= ovr_d;
      init_done   <= init_d;
      acc_gnt     <= gnt_d;
      bus_sel     <= gnt_d;
      ref_urgent  <= urgent_d;
      sch_cke     <= 1'b1;
      sch_cmd     <= cmd_d;
      sch_addr    <= addr_d;
      sch_ba      <= '0;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Self-checking bench for sdram_cmd_sched: a command-queue reference model
// built from the sequence/timing rules is compared with every output each cycle.
module tb_sdram_cmd_sched;

  localparam int PW   = 4;
  localparam int TRP  = 1;
  localparam int TRFC = 3;
  localparam int TMRD = 2;
  localparam int REFS = 2;
  localparam int RI   = 20;
  localparam logic [11:0] MR = 12'h010;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_DES = 4'b1111;

  logic        HCLK, HRESETn, acc_req, acc_done;
  logic        acc_gnt, ref_urgent, init_done, ref_overrun, bus_sel, sch_cke;
  logic [3:0]  sch_cmd;
  logic [11:0] sch_addr;
  logic [1:0]  sch_ba;
  logic [23:0] obs;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sdram_cmd_sched #(
    .PWRUP_CYC(PW), .TRP_CYC(TRP), .TRFC_CYC(TRFC), .TMRD_CYC(TMRD),
    .INIT_REFS(REFS), .REF_INTERVAL(RI), .MODE_REG(MR)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .acc_req(acc_req), .acc_done(acc_done),
    .acc_gnt(acc_gnt), .ref_urgent(ref_urgent), .init_done(init_done),
    .ref_overrun(ref_overrun), .bus_sel(bus_sel), .sch_cke(sch_cke),
    .sch_cmd(sch_cmd), .sch_addr(sch_addr), .sch_ba(sch_ba)
  );

  assign obs = {sch_cke, sch_cmd, sch_addr, sch_ba, bus_sel, acc_gnt, ref_urgent,
                init_done, ref_overrun};

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Reference model: commands still to be issued sit in a queue.
  logic [3:0] mq[$];
  logic [3:0] m_cmd;
  int         m_tmr;
  bit         m_rst, m_pend, m_ovr, m_init, m_gnt, m_idle;

  function automatic int nops(int n);
    return (n > 1) ? n - 1 : 1;
  endfunction

  function automatic void push_cmd_wait(logic [3:0] c, int n);
    mq.push_back(c);
    for (int i = 0; i < nops(n); i++) mq.push_back(C_NOP);
  endfunction

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < PW; i++) mq.push_back(C_NOP);
    push_cmd_wait(C_PRE, TRP);
    for (int r = 0; r < REFS; r++) push_cmd_wait(C_REF, TRFC);
    push_cmd_wait(C_LMR, TMRD);
    m_cmd = C_DES; m_tmr = 0;
    m_rst = 1; m_pend = 0; m_ovr = 0; m_init = 0; m_gnt = 0; m_idle = 0;
  endfunction

  function automatic void model_edge();
    bit expire, clr;
    expire = m_init && (m_tmr == RI - 1);
    clr    = 0;
    m_tmr  = (!m_init || expire) ? 0 : m_tmr + 1;
    m_rst  = 0;
    if (mq.size() > 0) begin
      m_cmd = mq.pop_front(); m_idle = 0; clr = (m_cmd == C_REF);
    end else if (m_gnt) begin
      m_cmd = C_NOP;
      if (acc_done) begin m_gnt = 0; m_idle = 1; end
    end else if (m_idle) begin
      if (m_pend) begin
        push_cmd_wait(C_PRE, TRP);
        push_cmd_wait(C_REF, TRFC);
        m_cmd = mq.pop_front(); m_idle = 0;
      end else if (acc_req) begin
        m_gnt = 1; m_idle = 0; m_cmd = C_NOP;
      end else m_cmd = C_NOP;
    end else begin
      m_idle = 1; m_init = 1; m_cmd = C_NOP;
    end
    m_ovr  = m_ovr | (expire & m_pend & !clr);
    m_pend = expire | (m_pend & !clr);
  endfunction

  function automatic logic [23:0] exp_vec();
    logic [11:0] a;
    a = (m_cmd == C_PRE) ? 12'h400 : (m_cmd == C_LMR) ? MR : 12'h000;
    if (m_rst) return {1'b0, C_DES, 12'h000, 2'b00, 5'b00000};
    return {1'b1, m_cmd, a, 2'b00, m_gnt, m_gnt, m_pend & m_gnt, m_init, m_ovr};
  endfunction

  task automatic tick();
    @(posedge HCLK);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; acc_req = 1'b0; acc_done = 1'b0;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1;
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", obs, exp_vec());
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  // Init sequence with random request noise that must be ignored.
  task automatic test_init();
    int start, rise;
    start = cyc; rise = -1;
    for (int i = 0; i < 100 && !m_init; i++) begin
      acc_req  = 1'($urandom);
      acc_done = 1'($urandom);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL init cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (init_done === 1'b1 && rise < 0) rise = cyc - start;
    end
    checks++;
    if (rise !== 15) begin
      errors++; $display("FAIL init_length got=%0d exp=15", rise);
    end
    acc_req = 1'b0; acc_done = 1'b0;
  endtask

  // Request held high with random done pulses: latency and re-grant gap.
  task automatic test_grant();
    acc_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      acc_done = m_gnt && ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL grant cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    acc_req = 1'b0; acc_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL grant_release cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    acc_done = 1'b0;
  endtask

  // No requests: refreshes recur exactly every interval.
  task automatic test_refresh_idle();
    int last, seen;
    last = -1; seen = 0;
    for (int i = 0; i < 75; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL refresh_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (sch_cmd === C_REF) begin
        seen++;
        if (seen >= 3) begin
          checks++;
          if (cyc - last !== RI) begin
            errors++; $display("FAIL refresh_spacing got=%0d exp=%0d", cyc - last, RI);
          end
        end
        last = cyc;
      end
    end
    checks++;
    if (seen < 3) begin
      errors++; $display("FAIL refresh_count got=%0d exp>=3", seen);
    end
  endtask

  // Obtain a grant (bounded wait), then hold it for n cycles.
  task automatic grab_and_hold(input int n, output bit saw_urgent);
    saw_urgent = 0;
    acc_req = 1'b1; acc_done = 1'b0;
    for (int i = 0; i < 60 && !m_gnt; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL grab cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    checks++;
    if (!m_gnt) begin
      errors++; $display("FAIL grab_timeout got=%b exp=1", acc_gnt);
    end
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL hold cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (ref_urgent === 1'b1) saw_urgent = 1;
    end
  endtask

  // Interval expires during a grant; refresh follows done despite acc_req.
  task automatic test_urgent();
    bit saw;
    grab_and_hold(25, saw);
    checks++;
    if (saw !== 1'b1) begin
      errors++; $display("FAIL ref_urgent got=%b exp=1", saw);
    end
    acc_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      acc_done = 1'b0;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL urgent_after cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
  endtask

  // Two intervals inside one grant: sticky overrun, single refresh after.
  task automatic test_overrun();
    bit saw;
    int refs;
    grab_and_hold(45, saw);
    checks++;
    if (ref_overrun !== 1'b1) begin
      errors++; $display("FAIL ref_overrun got=%b exp=1", ref_overrun);
    end
    acc_req = 1'b0; acc_done = 1'b1;
    refs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      acc_done = 1'b0;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL overrun_after cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (sch_cmd === C_REF) refs++;
    end
    checks++;
    if (refs !== 1) begin
      errors++; $display("FAIL overrun_ref_count got=%0d exp=1", refs);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      acc_req  = ($urandom_range(0, 3) != 0);
      acc_done = ($urandom_range(0, 4) == 0);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    acc_req = 1'b0; acc_done = 1'b0;
  endtask

  // Reset asserted during the post-REF wait of a periodic refresh.
  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      hit = m_init && (m_cmd == C_REF);
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL reset_mid_timeout got=%b exp=1", hit);
    end
    tick();
    #2 HRESETn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_mid got=%h exp=%h", obs, exp_vec());
    end
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
    test_grant();
    test_refresh_idle();
    test_urgent();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
